vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with registered sync,
// blanking and wrap markers. Every output comes straight from a flop.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FP     = 56,
   parameter int unsigned H_SYNC   = 120,
   parameter int unsigned H_BP     = 64,
   parameter int unsigned V_ACTIVE = 600,
   parameter int unsigned V_FP     = 37,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 23,
   parameter logic        SYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] count_rgb,
   output logic [9:0]  reset_count_rgb,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        eol,
   output logic        sof,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS        = 10'(V_ACTIVE);
   localparam logic [9:0]  V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        video_on_q, video_on_d;
   logic        eol_q, eol_d;
   logic        sof_q, sof_d;
   logic [7:0]  frame_q, frame_d;

   logic h_last, v_last, h_in_sync, v_in_sync, in_active;

   // Decodes look at the counters before they advance, which yields the
   // one-cycle lag of the sync/blank flags relative to the counters.
   always_comb begin
      h_last    = (h_q == H_LAST);
      v_last    = (v_q == V_LAST);
      h_in_sync = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
      v_in_sync = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
      in_active = (h_q < H_VIS) && (v_q < V_VIS);
   end

   always_comb begin
      h_d        = h_q;
      v_d        = v_q;
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      video_on_d = video_on_q;
      frame_d    = frame_q;
      eol_d      = 1'b0;
      sof_d      = 1'b0;
      if (en) begin
         h_d        = h_last ? 11'd0 : h_q + 11'd1;
         hsync_d    = h_in_sync ? SYNC_POL : ~SYNC_POL;
         vsync_d    = v_in_sync ? SYNC_POL : ~SYNC_POL;
         video_on_d = in_active;
         eol_d      = h_last;
         if (h_last) begin
            v_d = v_last ? 10'd0 : v_q + 10'd1;
         end
         if (h_last && v_last) begin
            sof_d   = 1'b1;
            frame_d = frame_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q        <= '0;
         v_q        <= '0;
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
         video_on_q <= 1'b0;
         eol_q      <= 1'b0;
         sof_q      <= 1'b0;
         frame_q    <= '0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
         eol_q      <= eol_d;
         sof_q      <= sof_d;
         frame_q    <= frame_d;
      end
   end

   assign count_rgb       = h_q;
   assign reset_count_rgb = v_q;
   assign hsync           = hsync_q;
   assign vsync           = vsync_q;
   assign video_on        = video_on_q;
   assign eol             = eol_q;
   assign sof             = sof_q;
   assign frame_cnt       = frame_q;

endmodule
